// File: rtl/oam_line_scanner_if.sv
// oam_line_scanner_if: OAM read port, line control and pixel lookup bundle.
// Carries overflow only when OAM_OVERFLOW_EN is defined.
interface oam_line_scanner_if #(
  parameter int AW = 3
);
  logic          line_start;
  logic [9:0]    scan_y;
  logic [AW-1:0] oam_rd_addr;
  logic [31:0]   oam_rd_data;
  logic          pix_valid;
  logic [9:0]    pix_x;
  logic          spr_hit;
  logic [11:0]   spr_addr;
  logic          scan_busy;
`ifdef OAM_OVERFLOW_EN
  logic          overflow;

  modport master (
    output line_start, scan_y, oam_rd_data,
    output pix_valid, pix_x,
    input  oam_rd_addr, spr_hit, spr_addr,
    input  scan_busy, overflow
  );

  modport slave (
    input  line_start, scan_y, oam_rd_data,
    input  pix_valid, pix_x,
    output oam_rd_addr, spr_hit, spr_addr,
    output scan_busy, overflow
  );
`else
  modport master (
    output line_start, scan_y, oam_rd_data,
    output pix_valid, pix_x,
    input  oam_rd_addr, spr_hit, spr_addr,
    input  scan_busy
  );

  modport slave (
    input  line_start, scan_y, oam_rd_data,
    input  pix_valid, pix_x,
    output oam_rd_addr, spr_hit, spr_addr,
    output scan_busy
  );
`endif
endinterface

// File: rtl/oam_line_scanner.sv
// oam_line_scanner: per-line OAM sprite evaluator with double line buffer.
// Optional sticky overflow flag: define OAM_OVERFLOW_EN.
module oam_line_scanner #(
  parameter int         NUM_OBJECTS  = 8,
  parameter int         MAX_PER_LINE = 4,
  parameter int         OBJ_SIZE     = 8,
  parameter logic [1:0] TYPE_MATCH   = 2'b01
) (
  input logic               clk,
  input logic               reset,
  oam_line_scanner_if.slave bus
);
  localparam int AW = (NUM_OBJECTS > 1) ? $clog2(NUM_OBJECTS) : 1;
  localparam int CW = $clog2(MAX_PER_LINE + 1);
  localparam int SW = 19;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [9:0]    scan_y_q;
  logic [SW-1:0] back_buf  [MAX_PER_LINE];
  logic [SW-1:0] front_buf [MAX_PER_LINE];
  logic [CW-1:0] back_cnt, front_cnt;

  logic [31:0]   wd;
  logic          eval_en, accept, full, wr_en;
  logic [10:0]   dy;
  logic [SW-1:0] new_slot;
  logic          unused_bits;

  assign wd          = bus.oam_rd_data;
  assign unused_bits = ^{wd[31], wd[7:6]};
  assign eval_en     = (state == SCAN && addr != '0)
                     || state == DRAIN;
  assign dy          = {1'b0, scan_y_q} - {1'b0, wd[17:8]};
  assign accept      = eval_en && wd[28]
                     && wd[30:29] == TYPE_MATCH
                     && !dy[10] && dy < 11'(OBJ_SIZE);
  assign full        = back_cnt == CW'(MAX_PER_LINE);
  assign wr_en       = accept && !full;
  assign new_slot    = {wd[27:18], dy[2:0], wd[5:3], wd[2:0]};

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    unique case (state)
      IDLE: ;
      SCAN: begin
        if (addr == AW'(NUM_OBJECTS - 1)) state_nxt = DRAIN;
        else addr_nxt = addr + AW'(1);
      end
      DRAIN: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.line_start) begin
      state_nxt = SCAN;
      addr_nxt  = '0;
    end
  end

  // On a swap the word evaluated this cycle still lands in the new front.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      back_cnt  <= '0;
      front_cnt <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      if (bus.line_start) begin
        scan_y_q  <= bus.scan_y;
        front_cnt <= back_cnt + CW'(wr_en);
        back_cnt  <= '0;
        for (int i = 0; i < MAX_PER_LINE; i++)
          front_buf[i] <= (wr_en && back_cnt == CW'(i))
                        ? new_slot : back_buf[i];
      end else if (wr_en) begin
        back_cnt <= back_cnt + CW'(1);
        for (int i = 0; i < MAX_PER_LINE; i++)
          if (back_cnt == CW'(i)) back_buf[i] <= new_slot;
      end
    end
  end

`ifdef OAM_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else if (accept && full) ovf_q <= 1'b1;
  end

  assign bus.overflow = ovf_q;
`endif

  logic [10:0] pxd [MAX_PER_LINE];
  logic        hit;
  logic [11:0] hit_addr;

  always_comb begin
    for (int i = 0; i < MAX_PER_LINE; i++)
      pxd[i] = {1'b0, bus.pix_x} - {1'b0, front_buf[i][18:9]};
  end

  // Walk downwards so the lowest slot index wins.
  always_comb begin
    hit      = 1'b0;
    hit_addr = '0;
    for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
      if (CW'(i) < front_cnt && !pxd[i][10]
          && pxd[i] < 11'(OBJ_SIZE)) begin
        hit      = 1'b1;
        hit_addr = {front_buf[i][5:0], front_buf[i][8:6],
                    pxd[i][2:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.spr_hit  <= 1'b0;
      bus.spr_addr <= '0;
    end else begin
      bus.spr_hit <= bus.pix_valid && hit;
      if (bus.pix_valid && hit) bus.spr_addr <= hit_addr;
    end
  end

  assign bus.oam_rd_addr = addr;
  assign bus.scan_busy   = state != IDLE;
endmodule

// File: tb/tb_oam_line_scanner.sv
// tb_oam_line_scanner: directed and randomized checks of oam_line_scanner
// against a list-based model of line evaluation and pixel lookup.
module tb_oam_line_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  oam_line_scanner_if #(.AW(3)) bus();

  oam_line_scanner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] oam [8];

  always @(posedge clk) bus.oam_rd_data <= oam[bus.oam_rd_addr];

  typedef struct {
    int x;
    int dy;
    int row;
    int col;
  } slot_t;

  slot_t front_q[$];
  slot_t back_q[$];
  bit    exp_ovf;
  int    total = 0;
  int    bad = 0;
  int    last_addr;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(int typ, int act, int x, int y,
                                     int row, int col);
    logic [31:0] w;
    w        = '0;
    w[30:29] = typ[1:0];
    w[28]    = act[0];
    w[27:18] = x[9:0];
    w[17:8]  = y[9:0];
    w[5:3]   = row[2:0];
    w[2:0]   = col[2:0];
    return w;
  endfunction

  // Entries 0..last_idx of the current OAM, accepted in index order.
  task automatic model_scan(int y, int last_idx);
    slot_t s;
    logic [31:0] w;
    int dy;
    back_q = {};
    for (int i = 0; i <= last_idx; i++) begin
      w  = oam[i];
      dy = y - int'(w[17:8]);
      if (w[28] && w[30:29] == 2'b01 && dy >= 0 && dy < 8) begin
        if (back_q.size() < 4) begin
          s.x   = int'(w[27:18]);
          s.dy  = dy;
          s.row = int'(w[5:3]);
          s.col = int'(w[2:0]);
          back_q.push_back(s);
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic model_pix(int x, output bit h, output int a);
    int px;
    h = 1'b0;
    a = 0;
    foreach (front_q[i]) begin
      px = x - front_q[i].x;
      if (!h && px >= 0 && px < 8) begin
        h = 1'b1;
        a = front_q[i].row * 512 + front_q[i].col * 64
          + front_q[i].dy * 8 + px;
      end
    end
  endtask

  task automatic pixel(string tag, int x, bit v);
    bit h;
    int a;
    @(negedge clk);
    bus.pix_x     = x[9:0];
    bus.pix_valid = v;
    @(negedge clk);
    model_pix(x, h, a);
    if (!v) h = 1'b0;
    check({tag, "_hit"}, 32'(bus.spr_hit), 32'(h));
    if (h) begin
      check({tag, "_addr"}, 32'(bus.spr_addr), 32'(a));
      last_addr = a;
    end
    if (!v) check({tag, "_hold"}, 32'(bus.spr_addr), 32'(last_addr));
    bus.pix_valid = 1'b0;
  endtask

  task automatic pulse(int y, int x, bit pv);
    bit h;
    int a;
    @(negedge clk);
    bus.line_start = 1'b1;
    bus.scan_y     = y[9:0];
    bus.pix_valid  = pv;
    bus.pix_x      = x[9:0];
    @(negedge clk);
    bus.line_start = 1'b0;
    bus.pix_valid  = 1'b0;
    if (pv) begin
      model_pix(x, h, a);
      check("swap_pix_hit", 32'(bus.spr_hit), 32'(h));
      if (h) begin
        check("swap_pix_addr", 32'(bus.spr_addr), 32'(a));
        last_addr = a;
      end
    end
    front_q = back_q;
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while (bus.scan_busy && n < 30) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'd9);
  endtask

  task automatic full_scan(int y);
    pulse(y, 0, 1'b0);
    wait_idle("scan_len");
    model_scan(y, 7);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    front_q   = {};
    back_q    = {};
    exp_ovf   = 1'b0;
    last_addr = 0;
  endtask

  task automatic check_ovf(string tag);
`ifdef OAM_OVERFLOW_EN
    check(tag, 32'(bus.overflow), 32'(exp_ovf));
`else
    check({tag, "_noovf_busy"}, 32'(bus.scan_busy), 32'd0);
`endif
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 8; i++) oam[i] = '0;
  endtask

  initial begin
    bus.line_start = 1'b0;
    bus.scan_y     = '0;
    bus.pix_valid  = 1'b0;
    bus.pix_x      = '0;
    clear_oam();
    do_reset();

    repeat (10) @(negedge clk);
    check("rst_hit", 32'(bus.spr_hit), 32'd0);
    check("rst_addr", 32'(bus.spr_addr), 32'd0);
    check("rst_busy", 32'(bus.scan_busy), 32'd0);
    check("rst_rdaddr", 32'(bus.oam_rd_addr), 32'd0);
    check_ovf("rst_ovf");

    oam[3] = mk(1, 1, 64, 96, 0, 2);
    full_scan(100);
    full_scan(100);
    pixel("t2_68", 68, 1'b1);
    check("t2_addr_const", 32'(bus.spr_addr), 32'd164);
    pixel("t2_72", 72, 1'b1);

    oam[3] = mk(1, 0, 64, 96, 0, 2);
    full_scan(100);
    full_scan(100);
    for (int x = 0; x < 1024; x++) pixel("t3_inact", x, 1'b1);
    oam[3] = mk(0, 1, 64, 96, 0, 2);
    full_scan(100);
    full_scan(100);
    for (int x = 0; x < 1024; x++) pixel("t3_type", x, 1'b1);

    clear_oam();
    for (int i = 0; i < 6; i++) oam[i] = mk(1, 1, 10 * (i + 1), 50, i, i);
    full_scan(52);
    full_scan(52);
    for (int i = 0; i < 6; i++) pixel("t4_six", 10 * (i + 1) + 1, 1'b1);
    check_ovf("t4_ovf");

    clear_oam();
    oam[1] = mk(1, 1, 40, 50, 5, 1);
    oam[2] = mk(1, 1, 44, 48, 3, 6);
    full_scan(50);
    full_scan(50);
    pixel("t5_45", 45, 1'b1);
    check("t5_addr_const", 32'(bus.spr_addr), 32'(5*512 + 64 + 5));
    pixel("t5_hold", 46, 1'b0);
    pixel("t5_49", 49, 1'b1);

    full_scan(200);
    pulse(300, 45, 1'b1);
    wait_idle("t7_len");
    model_scan(300, 7);
    pixel("t7_after", 45, 1'b1);

    clear_oam();
    for (int i = 0; i < 5; i++) oam[i] = mk(1, 1, 100 + 10 * i, 20, i, 7 - i);
    full_scan(500);
    pulse(22, 0, 1'b0);
    model_scan(22, 2);
    repeat (2) @(negedge clk);
    pulse(22, 0, 1'b0);
    wait_idle("t6_abort_len");
    model_scan(22, 7);
    for (int i = 0; i < 5; i++) pixel("t6_abort", 100 + 10 * i + 3, 1'b1);
    full_scan(22);
    pixel("t6_full", 133, 1'b1);

    pulse(22, 0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t9_busy", 32'(bus.scan_busy), 32'd0);
    check("t9_rdaddr", 32'(bus.oam_rd_addr), 32'd0);
    check("t9_hit", 32'(bus.spr_hit), 32'd0);
    reset     = 1'b0;
    front_q   = {};
    back_q    = {};
    exp_ovf   = 1'b0;
    last_addr = 0;
    pixel("t9_nohit", 103, 1'b1);
    check_ovf("t9_ovf");

    for (int it = 0; it < 25; it++) begin
      int base;
      base = $urandom_range(0, 1023);
      for (int i = 0; i < 8; i++) begin
        int typ, y;
        typ = ($urandom_range(0, 3) != 0) ? 1 : $urandom_range(0, 3);
        y   = (base + $urandom_range(0, 12) - 8) & 1023;
        oam[i] = mk(typ, ($urandom_range(0, 4) != 0) ? 1 : 0,
                    ($urandom_range(0, 5) != 0) ? $urandom_range(0, 80)
                                                : $urandom_range(0, 1023),
                    y, $urandom_range(0, 7), $urandom_range(0, 7));
        oam[i][31] = 1'($urandom_range(0, 1));
        oam[i][7:6] = 2'($urandom_range(0, 3));
      end
      full_scan(base);
      full_scan($urandom_range(0, 1023));
      for (int k = 0; k < 12; k++)
        pixel("rnd", $urandom_range(0, 90), $urandom_range(0, 7) != 0);
      check_ovf("rnd_ovf");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/oam_line_scanner.md
# oam_line_scanner

Per-scanline sprite evaluator on the read side of the object attribute memory (OAM) that the bullet engine writes. During horizontal blanking it walks every OAM entry and keeps up to MAX_PER_LINE visible 8×8 bullet sprites for the next line in a back buffer. At each line start the back buffer becomes the front buffer. For each active pixel it then returns a hit flag and a sprite-ROM address to the VGA compositor.

## Interface
- NUM_OBJECTS, 8: number of OAM entries scanned, addresses 0..NUM_OBJECTS-1.
- MAX_PER_LINE, 4: sprite slots per line buffer.
- OBJ_SIZE, 8: sprite width and height in pixels. Must be a power of two, at most 8.
- TYPE_MATCH, 2'b01: object type field value that is accepted (bullet).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- line_start  in  1  one-cycle pulse. Swap buffers and begin scanning for scan_y.
- scan_y  in  10  line number to evaluate; sampled on line_start.
- oam_rd_addr  out  $clog2(NUM_OBJECTS)  OAM read address.
- oam_rd_data  in  32  OAM word. Valid exactly 1 cycle after oam_rd_addr.
- pix_valid  in  1  active-video pixel strobe.
- pix_x  in  10  current pixel column.
- spr_hit  out  1  registered. A stored sprite covers pix_x.
- spr_addr  out  12  registered sprite-ROM address {rom_row, rom_col, py[2:0], px[2:0]}.
- scan_busy  out  1  high while the scan FSM is in SCAN or DRAIN.
- overflow  out  1  present only with OAM_OVERFLOW_EN. Sticky.

## Operation
- OAM word fields: [31] pad (ignored); [30:29] type; [28] active; [27:18] x; [17:8] y; [7:6] dir (ignored); [5:3] rom_row; [2:0] rom_col.
- An entry is accepted when all of the following hold:
  - active = 1;
  - type = TYPE_MATCH;
  - dy = scan_y − y, computed as an 11-bit signed difference, satisfies 0 ≤ dy < OBJ_SIZE.
- Each accepted entry is written to the next free back-buffer slot as {x, dy[2:0], rom_row, rom_col}. Slot order follows ascending OAM index.
- FSM states:
  - IDLE: on line_start, go to SCAN. Also: swap buffers, latch scan_y, clear the back count, set oam_rd_addr = 0.
  - SCAN: oam_rd_addr increments every cycle. The word returned for address k is evaluated one cycle later. After address NUM_OBJECTS-1 is issued, go to DRAIN.
  - DRAIN: evaluate the last word, then go to IDLE.
- The back buffer is full when its count = MAX_PER_LINE. Further accepted entries are dropped and the count saturates.
- Pixel lookup against the front buffer:
  - px = pix_x − slot.x, computed as an 11-bit signed difference.
  - A slot hits when 0 ≤ px < OBJ_SIZE and the slot index < front count.
  - When several slots hit, the lowest slot index wins (lowest OAM index drawn on top).
  - spr_addr = {rom_row, rom_col, slot.dy[2:0], px[2:0]}.
- When pix_valid = 0, spr_hit is forced to 0 on the next cycle and spr_addr holds its value.
- line_start while scan_busy: abort the current scan. The partially filled back buffer is swapped to the front with only its valid count. A fresh scan starts immediately for the new scan_y.
- line_start and a pixel lookup in the same cycle: the lookup uses the pre-swap front buffer.

## Timing
- Reset values:
  - state IDLE;
  - both buffer counts 0;
  - oam_rd_addr 0;
  - spr_hit 0;
  - spr_addr 0;
  - scan_busy 0;
  - overflow 0.
- Reset mid-scan returns the block to IDLE on the next edge. No buffer swap occurs.
- Scan length: NUM_OBJECTS + 1 cycles from line_start to scan_busy falling (9 cycles at the defaults).
- Pixel latency: 1 cycle from pix_valid/pix_x to spr_hit/spr_addr.
- The front buffer is stable between line_start pulses.
- line_start pulses must be at least 1 cycle apart. Back-to-back pulses are legal and follow the abort rule.

## Configuration
- OAM_OVERFLOW_EN defined:
  - overflow port present;
  - overflow is set in the cycle an accepted entry arrives while the back buffer is full;
  - it stays set until reset.
- OAM_OVERFLOW_EN undefined: no overflow port and no sticky register. Excess entries are silently dropped.

## Test plan
- Reset, then idle 10 cycles -> spr_hit=0, spr_addr=0, scan_busy=0, oam_rd_addr=0.
- Entry 3 = {type 01, active 1, x=64, y=96, rom_row=0, rom_col=2}. Scan scan_y=100, then pulse line_start again. Drive pix_x=68 -> one cycle later spr_hit=1, spr_addr={3'd0,3'd2,3'd4,3'd4}. Drive pix_x=72 -> spr_hit=0.
- Same entry with active=0, and separately with type=00 -> spr_hit=0 at every pix_x on the line.
- Six accepted entries at OAM indices 0..5, MAX_PER_LINE=4 -> front count 4 and entries 4 and 5 never hit. overflow=1 with OAM_OVERFLOW_EN.
- Entries 1 (x=40) and 2 (x=44) both cover line 50 -> at pix_x=45 spr_addr uses entry 1's rom fields with px=5.
- line_start, then a second line_start 4 cycles later -> front count reflects only entries accepted from addresses 0..2. The new scan runs a full 9 cycles.
